// File: rtl/osc_freq_meter_pkg.sv
// Shared types, default constants and helpers for the oscillator frequency meter.
package osc_freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_GATE_CYCLES = 27000;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_LO_LIMIT    = 1855;
  localparam int DEF_HI_LIMIT    = 2051;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/osc_edge_sync.sv
// Multi-flop synchroniser plus rising-edge detector for an asynchronous level.
module osc_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic rise
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   hist;

  // Reset to ones so a level already high at reset exit is not seen as a rise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain <= '1;
      hist  <= 1'b1;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], raw};
      hist  <= chain[SYNC_STAGES-1];
    end
  end

  assign rise = chain[SYNC_STAGES-1] & ~hist;

endmodule

// File: rtl/osc_freq_meter.sv
// Counts synchronised oscillator rising edges over a fixed clk gate window and flags range/overflow.
module osc_freq_meter
  import osc_freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int LO_LIMIT    = DEF_LO_LIMIT,
  parameter int HI_LIMIT    = DEF_HI_LIMIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             osc_in,
  input  logic             start,
  input  logic             continuous,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             in_range,
  output logic             overflow
);

  localparam int GATE_W = (clog2(GATE_CYCLES) < 1) ? 1 : clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  LO_C      = CNT_W'(LO_LIMIT);
  localparam logic [CNT_W-1:0]  HI_C      = CNT_W'(HI_LIMIT);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_GATE = GATE;
  localparam logic [1:0] ST_DONE = DONE;

  if (GATE_CYCLES < 1) begin : g_bad_gate
    $error("osc_freq_meter: GATE_CYCLES must be at least 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("osc_freq_meter: SYNC_STAGES must be at least 2");
  end
  if (LO_LIMIT > HI_LIMIT) begin : g_bad_order
    $error("osc_freq_meter: LO_LIMIT exceeds HI_LIMIT");
  end
  if ((HI_LIMIT >> CNT_W) != 0) begin : g_bad_hi
    $error("osc_freq_meter: HI_LIMIT does not fit in CNT_W bits");
  end

  logic              rise;
  logic [1:0]        state;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic [CNT_W-1:0]  edge_nxt;
  logic              ovf_int;
  logic              ovf_nxt;
  logic              arm;

  osc_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (osc_in),
    .rise  (rise)
  );

  // Saturating edge count; the final-cycle value feeds the result directly.
  always_comb begin
    edge_nxt = edge_cnt;
    ovf_nxt  = ovf_int;
    if (rise) begin
      if (edge_cnt == CNT_MAX) begin
        ovf_nxt = 1'b1;
      end else begin
        edge_nxt = edge_cnt + 1'b1;
      end
    end
  end

  assign arm  = ((state == ST_IDLE) && start) || ((state == ST_DONE) && continuous);
  assign busy = (state == ST_GATE);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      gate_cnt <= '0;
      count    <= '0;
      in_range <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arm) begin
            state    <= ST_GATE;
            gate_cnt <= GATE_LOAD;
          end
        end
        ST_GATE: begin
          gate_cnt <= gate_cnt - 1'b1;
          if (gate_cnt == '0) begin
            state    <= ST_DONE;
            count    <= edge_nxt;
            overflow <= ovf_nxt;
            in_range <= !ovf_nxt && (edge_nxt >= LO_C) && (edge_nxt <= HI_C);
          end
        end
        ST_DONE: begin
          if (arm) begin
            state    <= ST_GATE;
            gate_cnt <= GATE_LOAD;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Edge counter is cleared on every arm, so it needs no reset of its own.
  always_ff @(posedge clk) begin
    if (arm) begin
      edge_cnt <= '0;
      ovf_int  <= 1'b0;
    end else if (state == ST_GATE) begin
      edge_cnt <= edge_nxt;
      ovf_int  <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_osc_freq_meter.sv
// Scoreboard bench for osc_freq_meter: an 8-bit instance and a 5-bit instance for saturation.
module tb_osc_freq_meter;

  localparam int G    = 100;
  localparam int LO   = 20;
  localparam int HI   = 30;
  localparam int MAXC = 8192;

  typedef struct {
    int exp_cnt;
    int tol;
    int due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       osc = 1'b1;
  logic       osc5 = 1'b0;
  logic       start = 1'b0;
  logic       start5 = 1'b0;
  logic       continuous = 1'b0;
  logic       busy, done, in_range, overflow;
  logic [7:0] count;
  logic       busy5, done5, in_range5, overflow5;
  logic [4:0] count5;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   log0 [0:MAXC-1];
  bit   log5 [0:MAXC-1];
  exp_t q0[$];
  exp_t q5[$];

  bit   osc_const = 1'b1;
  bit   osc_const_val = 1'b1;
  int   osc_hi = 2;
  int   osc_lo = 2;
  int   ph = 0;

  osc_freq_meter #(
    .GATE_CYCLES(G), .CNT_W(8), .SYNC_STAGES(2), .LO_LIMIT(LO), .HI_LIMIT(HI)
  ) dut (
    .clk(clk), .rst_n(rst_n), .osc_in(osc), .start(start), .continuous(continuous),
    .busy(busy), .done(done), .count(count), .in_range(in_range), .overflow(overflow)
  );

  osc_freq_meter #(
    .GATE_CYCLES(G), .CNT_W(5), .SYNC_STAGES(2), .LO_LIMIT(LO), .HI_LIMIT(HI)
  ) dut5 (
    .clk(clk), .rst_n(rst_n), .osc_in(osc5), .start(start5), .continuous(1'b0),
    .busy(busy5), .done(done5), .count(count5), .in_range(in_range5), .overflow(overflow5)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Oscillator sources, driven on the falling edge; every 0->1 transition is logged by cycle.
  always @(negedge clk) begin
    logic prev;
    prev = osc;
    if (osc_const) begin
      osc = osc_const_val;
      ph  = 0;
    end else begin
      ph++;
      if (osc && ph >= osc_hi) begin
        osc = 1'b0;
        ph  = 0;
      end else if (!osc && ph >= osc_lo) begin
        osc = 1'b1;
        ph  = 0;
      end
    end
    if (!prev && osc && cyc < MAXC) log0[cyc] = 1'b1;
    osc5 = ~osc5;
    if (osc5 && cyc < MAXC) log5[cyc] = 1'b1;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic chk_near(input string name, input int got, input int want, input int tol);
    total++;
    if (got < want - tol || got > want + tol) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d+-%0d (cycle %0d)", name, got, want, tol, cyc);
    end
  endtask

  // Rises launched while the window (start sampled at s+1, GATE for G cycles) is open,
  // allowing for the synchroniser delay.
  function automatic int model_rises(input bit which, input int s);
    int n;
    n = 0;
    for (int k = s - 1; k <= s + G - 2; k++) begin
      if (k >= 0 && k < MAXC) begin
        if (which ? log5[k] : log0[k]) n++;
      end
    end
    return n;
  endfunction

  task automatic check_result(input string tag, input int got_cnt, input bit got_ir,
                              input bit got_ovf, input exp_t e, input int maxv);
    int  e_lo, e_hi;
    bit  ok;
    e_lo = e.exp_cnt - e.tol;
    e_hi = e.exp_cnt + e.tol;
    chk({tag, "_done_cycle"}, cyc, e.due);
    if (e_lo > maxv) begin
      chk({tag, "_sat_count"}, got_cnt, maxv);
      chk({tag, "_sat_ovf"}, got_ovf, 1);
      chk({tag, "_sat_in_range"}, got_ir, 0);
    end else if (e_hi <= maxv) begin
      chk({tag, "_ovf"}, got_ovf, 0);
      chk_near({tag, "_count"}, got_cnt, e.exp_cnt, e.tol);
      if (e_lo >= LO && e_hi <= HI) chk({tag, "_in_range"}, got_ir, 1);
      else if (e_hi < LO || e_lo > HI) chk({tag, "_in_range"}, got_ir, 0);
      else chk({tag, "_in_range_rule"}, got_ir, (got_cnt >= LO && got_cnt <= HI) ? 1 : 0);
    end else begin
      total++;
      ok = got_ovf ? (got_cnt == maxv && !got_ir)
                   : (got_cnt >= e_lo && got_cnt <= e_hi);
      if (!ok) begin
        bad++;
        $display("FAIL %s_edge_sat: got count=%0d ovf=%0d ir=%0d, want ~%0d",
                 tag, got_cnt, got_ovf, got_ir, e.exp_cnt);
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (q0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dut_unexpected_done: got done=1, want 0 (cycle %0d)", cyc);
      end else begin
        e = q0.pop_front();
        check_result("dut", int'(count), in_range, overflow, e, 255);
      end
    end
    if (done5) begin
      if (q5.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dut5_unexpected_done: got done=1, want 0 (cycle %0d)", cyc);
      end else begin
        e = q5.pop_front();
        check_result("dut5", int'(count5), in_range5, overflow5, e, 31);
      end
    end
  end

  task automatic measure(input int tol, input bit pulse);
    int   s;
    exp_t e;
    s = cyc;
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("busy_first", busy, 1);
    for (int c = s + 2; c <= s + G; c++) begin
      step(1);
      start = pulse && (c % 17 == 0);
    end
    chk("busy_last", busy, 1);
    e.exp_cnt = model_rises(1'b0, s);
    e.tol     = tol;
    e.due     = s + G + 1;
    q0.push_back(e);
    step(1);
    start = pulse;
    chk("busy_in_done", busy, 0);
    step(1);
    start = 1'b0;
    step(2);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    int   s;
    exp_t e;
    step(3);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    chk("rst_in_range", in_range, 0);
    chk("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    step(2);

    // Constant high oscillator across reset exit.
    measure(0, 1'b0);

    // Period-4 oscillator.
    osc_const = 1'b0;
    osc_hi = 2;
    osc_lo = 2;
    step(5);
    measure(1, 1'b0);

    // Saturation on the 5-bit instance.
    s = cyc;
    start5 = 1'b1;
    step(1);
    start5 = 1'b0;
    while (cyc < s + G) step(1);
    e.exp_cnt = model_rises(1'b1, s);
    e.tol     = 1;
    e.due     = s + G + 1;
    q5.push_back(e);
    step(4);

    // Continuous back-to-back windows; continuous drops during the fourth.
    continuous = 1'b1;
    s = cyc;
    start = 1'b1;
    step(1);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        while (cyc < s + i * (G + 1) + 5) step(1);
        continuous = 1'b0;
      end
      while (cyc < s + i * (G + 1) + G) step(1);
      e.exp_cnt = model_rises(1'b0, s + i * (G + 1));
      e.tol     = 1;
      e.due     = s + i * (G + 1) + G + 1;
      q0.push_back(e);
    end
    step(G + 10);
    chk("cont_stopped_busy", busy, 0);

    // Reset in the middle of a window.
    s = cyc;
    start = 1'b1;
    step(1);
    start = 1'b0;
    while (cyc < s + 50) step(1);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_count", count, 0);
    chk("abort_in_range", in_range, 0);
    chk("abort_overflow", overflow, 0);
    step(G + 10);
    measure(1, 1'b0);

    // Start pulses during GATE and DONE are ignored.
    measure(1, 1'b1);

    // Randomised oscillator shapes.
    for (int r = 0; r < 8; r++) begin
      osc_hi = $urandom_range(1, 4);
      osc_lo = $urandom_range(1, 4);
      step($urandom_range(2, 9));
      measure(1, r[0]);
    end

    step(5);
    chk("q0_drained", q0.size(), 0);
    chk("q5_drained", q5.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
